// File: rtl/mux_dispatch1to3.sv
// Purpose: registered 1-to-3 dispatcher; one producer word is steered into one of three single-entry slots.
// Latency: a word accepted at edge N is visible on dout_s with out_valid[s]=1 right after edge N.
// Backpressure: in_ready is per selected slot (empty or acked this cycle); sel=2'b11 is always accepted and dropped.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   din, sel          word to dispatch and its destination (00/01/10 = slot 1/2/3, 11 = invalid)
//   in_valid/in_ready producer handshake; in_ready is combinational from sel, out_valid, out_ack
//   dout1..dout3      slot data registers
//   out_valid/out_ack per-slot consumer handshake (bit k-1 = slot k)
//   err               one-cycle pulse after an accepted sel=2'b11 transfer
//   drop_count        saturating count of accepted sel=2'b11 transfers
module mux_dispatch1to3 #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] din,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] dout1,
    output logic [width-1:0] dout2,
    output logic [width-1:0] dout3,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ack,
    output logic             err,
    output logic [7:0]       drop_count
);

    logic       xfer;
    logic [2:0] wr;
    logic       drop;
    logic [2:0] valid_nxt;

    // A slot can take a new word when it is empty or being drained this same cycle.
    always_comb begin
        in_ready = 1'b1;
        case (sel)
            2'b00:   in_ready = ~out_valid[0] | out_ack[0];
            2'b01:   in_ready = ~out_valid[1] | out_ack[1];
            2'b10:   in_ready = ~out_valid[2] | out_ack[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign xfer = in_valid & in_ready;
    assign drop = xfer & (sel == 2'b11);

    always_comb begin
        wr = 3'b000;
        if (xfer) begin
            case (sel)
                2'b00:   wr = 3'b001;
                2'b01:   wr = 3'b010;
                2'b10:   wr = 3'b100;
                default: wr = 3'b000;
            endcase
        end
    end

    // Write wins over ack on the same slot, giving bubble-free pass-through refill.
    assign valid_nxt = (out_valid & ~out_ack) | wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout1      <= '0;
            dout2      <= '0;
            dout3      <= '0;
            out_valid  <= 3'b000;
            err        <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            if (wr[0]) dout1 <= din;
            if (wr[1]) dout2 <= din;
            if (wr[2]) dout3 <= din;
            out_valid <= valid_nxt;
            err       <= drop;
            if (drop && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_mux_dispatch1to3.sv
module tb_mux_dispatch1to3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic [1:0]  sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout1, dout2, dout3;
    logic [2:0]  out_valid;
    logic [2:0]  out_ack;
    logic        err;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: slot contents and occupancy as plain arrays.
    logic [31:0] m_dout [3];
    bit          m_vld  [3];
    bit          m_err;
    int          m_cnt;

    mux_dispatch1to3 #(.width(32)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .dout1(dout1), .dout2(dout2), .dout3(dout3),
        .out_valid(out_valid), .out_ack(out_ack), .err(err), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_dout[k] = '0;
            m_vld[k]  = 1'b0;
        end
        m_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic check_all();
        chk("dout1", dout1, m_dout[0]);
        chk("dout2", dout2, m_dout[1]);
        chk("dout3", dout3, m_dout[2]);
        chk("out_valid", out_valid, {m_vld[2], m_vld[1], m_vld[0]});
        chk("err", err, m_err);
        chk("drop_count", drop_count, m_cnt);
    endtask

    // One clock of stimulus: drive mid-cycle, check in_ready, clock, update model, check outputs.
    task automatic step(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [2:0] a);
        bit exp_rdy;
        int tgt;
        din = d; sel = s; in_valid = v; out_ack = a;
        #1;
        tgt = int'(s);
        if (tgt == 3) exp_rdy = 1'b1;
        else          exp_rdy = !m_vld[tgt] || a[tgt];
        chk("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        m_err = 1'b0;
        for (int k = 0; k < 3; k++)
            if (a[k]) m_vld[k] = 1'b0;
        if (v && exp_rdy) begin
            if (tgt == 3) begin
                m_err = 1'b1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end else begin
                m_dout[tgt] = d;
                m_vld[tgt]  = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; din = '0; sel = 2'b00; in_valid = 1'b0; out_ack = 3'b000;
        model_reset();
        #3;
        // Inputs active while reset is held: nothing may change.
        din = 32'h2; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_outputs", {dout1, dout2, dout3, out_valid, err, drop_count}, 108'h0);
        rst_n = 1'b1;

        step(32'h2, 2'b00, 1'b1, 3'b000);
        chk("first_dout1", dout1, 32'h2);
        chk("first_valid", out_valid, 3'b001);
        chk("first_dout23", {dout2, dout3}, 64'h0);

        step(32'h3, 2'b01, 1'b1, 3'b000);
        step(32'h7, 2'b01, 1'b1, 3'b000);
        chk("slot2_held", dout2, 32'h3);
        step(32'h7, 2'b01, 1'b1, 3'b010);
        chk("slot2_refill", dout2, 32'h7);
        chk("slot2_valid", out_valid[1], 1'b1);

        step(32'h9, 2'b10, 1'b1, 3'b000);
        chk("all_full", out_valid, 3'b111);
        step(32'h0, 2'b00, 1'b0, 3'b101);
        chk("drain_valid", out_valid, 3'b010);
        chk("drain_keep", {dout1, dout3}, {32'h2, 32'h9});

        for (int i = 0; i < 3; i++) begin
            step(32'h4, 2'b11, 1'b1, 3'b000);
            chk("err_pulse", err, 1'b1);
        end
        chk("drop3", drop_count, 8'd3);
        step(32'h0, 2'b00, 1'b0, 3'b100);
        chk("err_clear", err, 1'b0);
        chk("spurious_ack", out_valid, 3'b010);

        for (int i = 0; i < 297; i++)
            step(32'h4, 2'b11, 1'b1, 3'b000);
        chk("drop_sat", drop_count, 8'hFF);

        for (int i = 0; i < 400; i++)
            step($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)));

        step(32'hA1, 2'b00, 1'b1, 3'b111);
        step(32'hB2, 2'b01, 1'b1, 3'b000);
        step(32'hC3, 2'b10, 1'b1, 3'b000);
        step(32'hD4, 2'b11, 1'b1, 3'b000);
        chk("prereset_full", out_valid, 3'b111);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 3'b000);
        chk("async_rst_dout", {dout1, dout2, dout3}, 96'h0);
        chk("async_rst_cnt", drop_count, 8'h00);
        chk("async_rst_err", err, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++)
            step($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
